led_7seg_scan: RTL and testbench



---
 rtl/led_7seg_scan.sv | 186 ++++++++++++++++++
 tb/tb_led_7seg_scan.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_7seg_scan.sv
// led_7seg_scan: multiplexed 7-segment driver with one lit digit per scan slot.
// Supports hex/decimal decode, decimal points, leading-zero blanking,
// per-digit blink, a frame-coherent input snapshot and an anti-ghost blank tail.
// Segment and common outputs are active low and registered.
module led_7seg_scan #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 16384,
    parameter int BLANK_CYC    = 4096,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_xrst,
    input  logic                  i_en,
    input  logic                  i_hexMode,
    input  logic                  i_lzb,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_blink,
    output logic [7:0]            o_led7Seg,
    output logic [DIGITS-1:0]     o_led7Com,
    output logic                  o_frame
);

    localparam int SC_W = $clog2(SCAN_DIV);
    localparam int DI_W = $clog2(DIGITS);
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SC_W-1:0] SC_LAST    = SC_W'(SCAN_DIV - 1);
    localparam logic [SC_W:0]   SC_LIT_END = (SC_W + 1)'(SCAN_DIV - BLANK_CYC);
    localparam logic [DI_W-1:0] DI_LAST    = DI_W'(DIGITS - 1);
    localparam logic [FC_W-1:0] FC_LAST    = FC_W'(BLINK_FRAMES - 1);

    logic [SC_W-1:0]     r_sc;
    logic [DI_W-1:0]     r_di;
    logic [FC_W-1:0]     r_fc;
    logic                r_bp;

    logic [4*DIGITS-1:0] r_dataSnap;
    logic [DIGITS-1:0]   r_dpSnap;
    logic [DIGITS-1:0]   r_blinkSnap;
    logic                r_hexSnap;
    logic                r_lzbSnap;

    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_com;
    logic                r_frame;

    logic                w_slotEnd;
    logic                w_frameEnd;
    logic                w_lit;
    logic [3:0]          w_nibble;
    logic                w_dpBit;
    logic                w_blinkBit;
    logic                w_lzBlank;
    logic [DIGITS-1:0]   w_lzMask;
    logic [6:0]          w_seg7;
    logic [7:0]          w_segNext;
    logic [DIGITS-1:0]   w_comNext;

    assign w_slotEnd  = (r_sc == SC_LAST);
    assign w_frameEnd = w_slotEnd && (r_di == DI_LAST);
    assign w_lit      = ({1'b0, r_sc} < SC_LIT_END);

    // Leading-zero mask: a digit above 0 is blank when it and every higher nibble is zero
    always_comb begin
        logic zeroRun;
        zeroRun  = 1'b1;
        w_lzMask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zeroRun     = zeroRun && (r_dataSnap[4*i +: 4] == 4'h0);
            w_lzMask[i] = zeroRun && (i != 0) && r_lzbSnap;
        end
    end

    // Select the snapshot fields of the digit currently being scanned
    always_comb begin
        w_nibble   = 4'h0;
        w_dpBit    = 1'b0;
        w_blinkBit = 1'b0;
        w_lzBlank  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_di == DI_W'(i)) begin
                w_nibble   = r_dataSnap[4*i +: 4];
                w_dpBit    = r_dpSnap[i];
                w_blinkBit = r_blinkSnap[i];
                w_lzBlank  = w_lzMask[i];
            end
        end
    end

    // Nibble to g..a pattern, with decimal-mode and leading-zero blanking
    always_comb begin
        case (w_nibble)
            4'h0: w_seg7 = 7'b1000000;
            4'h1: w_seg7 = 7'b1111001;
            4'h2: w_seg7 = 7'b0100100;
            4'h3: w_seg7 = 7'b0110000;
            4'h4: w_seg7 = 7'b0011001;
            4'h5: w_seg7 = 7'b0010010;
            4'h6: w_seg7 = 7'b0000010;
            4'h7: w_seg7 = 7'b1111000;
            4'h8: w_seg7 = 7'b0000000;
            4'h9: w_seg7 = 7'b0010000;
            4'hA: w_seg7 = 7'b0001000;
            4'hB: w_seg7 = 7'b0000011;
            4'hC: w_seg7 = 7'b1000110;
            4'hD: w_seg7 = 7'b0100001;
            4'hE: w_seg7 = 7'b0000110;
            default: w_seg7 = 7'b0001110;
        endcase
        if (w_lzBlank || (!r_hexSnap && (w_nibble > 4'h9))) begin
            w_seg7 = 7'b1111111;
        end
    end

    // Next segment byte (blink overrides everything) and next common pattern
    always_comb begin
        w_segNext = {~w_dpBit, w_seg7};
        if (w_blinkBit && r_bp) begin
            w_segNext = 8'hFF;
        end
        w_comNext = '1;
        for (int i = 0; i < DIGITS; i++) begin
            w_comNext[i] = ~(w_lit && (r_di == DI_W'(i)));
        end
    end

    // Scan counters, input snapshot and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_xrst) begin
            r_sc        <= '0;
            r_di        <= '0;
            r_fc        <= '0;
            r_bp        <= 1'b0;
            r_dataSnap  <= '0;
            r_dpSnap    <= '0;
            r_blinkSnap <= '0;
            r_hexSnap   <= 1'b0;
            r_lzbSnap   <= 1'b0;
            r_seg       <= 8'hFF;
            r_com       <= '1;
            r_frame     <= 1'b0;
        end else if (!i_en) begin
            r_sc        <= '0;
            r_di        <= '0;
            r_fc        <= '0;
            r_bp        <= 1'b0;
            r_dataSnap  <= i_data;
            r_dpSnap    <= i_dp;
            r_blinkSnap <= i_blink;
            r_hexSnap   <= i_hexMode;
            r_lzbSnap   <= i_lzb;
            r_seg       <= 8'hFF;
            r_com       <= '1;
            r_frame     <= 1'b0;
        end else begin
            r_seg   <= w_segNext;
            r_com   <= w_comNext;
            r_frame <= w_frameEnd;
            if (w_slotEnd) begin
                r_sc <= '0;
                r_di <= (r_di == DI_LAST) ? '0 : r_di + 1'b1;
            end else begin
                r_sc <= r_sc + 1'b1;
            end
            if (w_frameEnd) begin
                r_dataSnap  <= i_data;
                r_dpSnap    <= i_dp;
                r_blinkSnap <= i_blink;
                r_hexSnap   <= i_hexMode;
                r_lzbSnap   <= i_lzb;
                if (r_fc == FC_LAST) begin
                    r_fc <= '0;
                    r_bp <= ~r_bp;
                end else begin
                    r_fc <= r_fc + 1'b1;
                end
            end
        end
    end

    assign o_led7Seg = r_seg;
    assign o_led7Com = r_com;
    assign o_frame   = r_frame;

endmodule

// File: tb/tb_led_7seg_scan.sv
// tb_led_7seg_scan: directed and randomized checks of led_7seg_scan against
// a time-position reference model (digit, frame and blink phase are derived
// arithmetically from the number of enabled cycles).
module tb_led_7seg_scan;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYC    = 2;
    localparam int BLINK_FRAMES = 2;

    logic        clk = 1'b0;
    logic        xrst;
    logic        en;
    logic        hexMode;
    logic        lzb;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blink;
    logic [7:0]  led7Seg;
    logic [3:0]  led7Com;
    logic        frame;

    int checks   = 0;
    int failures = 0;

    logic [6:0] segTab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int          tEn;
    logic [15:0] snapData;
    logic [3:0]  snapDp;
    logic [3:0]  snapBlink;
    logic        snapHex;
    logic        snapLzb;
    logic [7:0]  expSeg;
    logic [3:0]  expCom;
    logic        expFrame;

    led_7seg_scan #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .i_clk     (clk),
        .i_xrst    (xrst),
        .i_en      (en),
        .i_hexMode (hexMode),
        .i_lzb     (lzb),
        .i_data    (data),
        .i_dp      (dp),
        .i_blink   (blink),
        .o_led7Seg (led7Seg),
        .o_led7Com (led7Com),
        .o_frame   (frame)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference model: advance one clock edge using the inputs present at it
    task automatic modelEdge();
        int         pos;
        int         slot;
        int         dig;
        int         frm;
        logic       bp;
        logic [3:0] nib;
        logic [6:0] code;
        logic       lzBlank;
        if (xrst) begin
            tEn = 0; snapData = '0; snapDp = '0; snapBlink = '0; snapHex = 1'b0; snapLzb = 1'b0;
            expSeg = 8'hFF; expCom = 4'hF; expFrame = 1'b0;
        end else if (!en) begin
            tEn = 0; snapData = data; snapDp = dp; snapBlink = blink; snapHex = hexMode; snapLzb = lzb;
            expSeg = 8'hFF; expCom = 4'hF; expFrame = 1'b0;
        end else begin
            pos  = tEn % SCAN_DIV;
            slot = tEn / SCAN_DIV;
            dig  = slot % DIGITS;
            frm  = slot / DIGITS;
            bp   = ((frm / BLINK_FRAMES) % 2) == 1;
            nib  = snapData[4*dig +: 4];
            lzBlank = snapLzb && (dig >= 1) && ((snapData >> (4*dig)) == 16'h0);
            code = (lzBlank || (!snapHex && nib > 4'd9)) ? 7'h7F : segTab[nib];
            expSeg = (snapBlink[dig] && bp) ? 8'hFF : {~snapDp[dig], code};
            expCom = (pos < SCAN_DIV - BLANK_CYC) ? ~(4'b0001 << dig) : 4'hF;
            expFrame = (pos == SCAN_DIV - 1) && (dig == DIGITS - 1);
            if (expFrame) begin
                snapData = data; snapDp = dp; snapBlink = blink; snapHex = hexMode; snapLzb = lzb;
            end
            tEn++;
        end
    endtask

    // One counted comparison
    task automatic expectEq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model
    task automatic checkOutput(input string tag);
        expectEq({tag, "_seg"}, led7Seg, expSeg);
        expectEq({tag, "_com"}, {4'h0, led7Com}, {4'h0, expCom});
        expectEq({tag, "_frame"}, {7'h0, frame}, {7'h0, expFrame});
    endtask

    // Drive the functional inputs (reset is driven separately)
    task automatic applyStimulus(input logic e, input logic h, input logic l,
                                 input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        en = e; hexMode = h; lzb = l; data = d; dp = p; blink = b;
    endtask

    // Advance n cycles, checking the model after each edge
    task automatic runCycles(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            modelEdge();
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    // Directed scenarios followed by a randomized soak
    initial begin
        xrst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);
        runCycles(2, "reset");
        expectEq("reset_seg_ff", led7Seg, 8'hFF);

        xrst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 4'h0, 4'h0);
        runCycles(2, "idle");

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 4'h0, 4'h0);
        runCycles(1, "scan");
        expectEq("scan_dig0_seg", led7Seg, 8'h99);
        expectEq("scan_dig0_com", {4'h0, led7Com}, 8'h0E);
        runCycles(24, "scan");
        expectEq("scan_dig3_seg", led7Seg, 8'hF9);
        expectEq("scan_dig3_com", {4'h0, led7Com}, 8'h07);
        runCycles(7, "scan");
        expectEq("scan_frame", {7'h0, frame}, 8'h01);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h00AF, 4'h0, 4'h0);
        runCycles(33, "hex");
        expectEq("hex_dig0_F", led7Seg, 8'h8E);
        runCycles(8, "hex");
        expectEq("hex_dig1_A", led7Seg, 8'h88);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h00AF, 4'h0, 4'h0);
        runCycles(24, "dec");
        expectEq("dec_dig0_blank", led7Seg, 8'hFF);

        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0050, 4'b0100, 4'h0);
        runCycles(32, "lzb");
        expectEq("lzb_dig0", led7Seg, 8'hC0);
        runCycles(8, "lzb");
        expectEq("lzb_dig1", led7Seg, 8'h92);
        runCycles(8, "lzb");
        expectEq("lzb_dig2_dp", led7Seg, 8'h7F);
        runCycles(8, "lzb");
        expectEq("lzb_dig3", led7Seg, 8'hFF);

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1111, 4'h0, 4'h0);
        runCycles(16, "snap");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h2222, 4'h0, 4'h0);
        runCycles(8, "snap");
        expectEq("snap_old", led7Seg, 8'hF9);
        runCycles(16, "snap");
        expectEq("snap_new", led7Seg, 8'hA4);

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h2222, 4'h0, 4'b0001);
        runCycles(32, "blink");
        expectEq("blink_off", led7Seg, 8'hFF);
        runCycles(32, "blink");
        expectEq("blink_on", led7Seg, 8'hA4);

        runCycles(18, "rstmid");
        xrst = 1'b1;
        runCycles(1, "rstmid");
        expectEq("rstmid_com", {4'h0, led7Com}, 8'h0F);
        xrst = 1'b0;
        runCycles(1, "rstmid");
        expectEq("rstmid_restart", {4'h0, led7Com}, 8'h0E);

        runCycles(5, "enfall");
        en = 1'b0;
        runCycles(1, "enfall");
        expectEq("enfall_dark", led7Seg, 8'hFF);
        en = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) data = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blink = 4'($urandom);
            if ($urandom_range(0, 31) == 0) hexMode = ~hexMode;
            if ($urandom_range(0, 31) == 0) lzb = ~lzb;
            if ($urandom_range(0, 199) == 0) en = ~en;
            if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            xrst = ($urandom_range(0, 399) == 0);
            runCycles(1, "rand");
        end
        xrst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
